bcd_converter_seq: RTL and testbench
====================================

# bcd_converter_seq

Sequential binary-to-BCD converter that sits between the 16-bit event counter and the four-digit seven-segment multiplexer. On a start request it captures the counter value and converts it with shift-and-add-3 (double dabble), one bit per clock. It presents four packed BCD digits plus an overflow flag for values that need a fifth decimal digit. This lets the display show decimal counts instead of hex.

## Interface

Parameters:
- None. Widths are fixed: 16-bit binary in, 4 BCD digits out.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  conversion request; sampled only in IDLE
- bin_in  input  16  unsigned binary value, captured on the accepted start edge
- bcd_out  output  16  packed BCD digits; [15:12]=thousands, [11:8]=hundreds, [7:4]=tens, [3:0]=ones
- overflow  output  1  high when the last converted value was ≥ 10000
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd_out/overflow update

## Operation

- States:
  - IDLE: busy=0; waits for start.
  - CONV: performs 16 shift iterations, one per clock.
- Accept: on an edge with state=IDLE and start=1:
  - bin_in loads into a 16-bit shift register.
  - The 20-bit BCD work register (5 digits) clears to 0.
  - Iteration counter clears to 0; state→CONV; busy→1.
- Each edge in CONV:
  - Every 4-bit digit of the work register that is ≥5 gets +3.
  - Then the work register and shift register shift left as one {work, shift} unit; the shift register MSB enters work[0].
  - The iteration counter increments.
- Final iteration, on the CONV edge with counter=15:
  - Perform that edge's add/shift.
  - bcd_out ← low 16 bits of the resulting work register.
  - overflow ← (top digit ≠ 0).
  - done→1 and busy→0; state→IDLE.
- Out-of-range values: bcd_out shows value mod 10000 (e.g. 65535 → 5535) and overflow=1.
- Outputs between conversions:
  - bcd_out and overflow hold their last values until the next completion.
  - They never show intermediate work-register contents.
- start while busy: ignored, not queued.
- bin_in changes after the accept edge: no effect on the current conversion.
- Each add-3 check uses its digit's value before the shift, so no digit exceeds 9 after any shift.

## Timing

- Reset (synchronous) result: state=IDLE, bcd_out=16'h0000, overflow=0, busy=0, done=0, all internal registers 0.
- Reset wins over start and over any in-progress conversion. A conversion interrupted by reset is abandoned; no done pulse.
- Latency, with start accepted at edge N:
  - busy=1 after edges N…N+15.
  - Results and done=1 after edge N+16.
  - done=0 after edge N+17.
- Throughput:
  - state is still CONV at edge N+16, so start is ignored there.
  - The next accept is possible at edge N+17.
  - start held high continuously gives one conversion every 17 cycles, with done pulsing every 17 cycles.
- done is registered, exactly one cycle wide, and never asserted together with busy.
- There is no combinational path from inputs to outputs.

## Test plan

- After reset, start with bin_in=0 → 16 cycles later bcd_out=16'h0000, overflow=0, done one cycle; busy high for exactly 16 cycles.
- bin_in=16'd1234 → bcd_out=16'h1234, overflow=0. bin_in=16'd9999 → bcd_out=16'h9999, overflow=0.
- bin_in=16'd10000 → bcd_out=16'h0000, overflow=1. bin_in=16'd65535 → bcd_out=16'h5535, overflow=1.
- Start with bin_in=42, then pulse start and change bin_in to 7 mid-conversion → one done only, bcd_out=16'h0042; a later start with bin_in=7 → 16'h0007.
- Start held high with bin_in sweeping 0→65535 → done period 17 cycles; each result matches a decimal reference model (value mod 10000, overflow = value ≥ 10000).
- Convert 1234, then start 5678 and assert reset at iteration 8 → next cycle bcd_out=0, overflow=0, busy=0, no done; a following start with 5678 → 16'h5678.

Source files
------------

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq
//   Sequential 16-bit binary to 4-digit packed BCD converter using
//   shift-and-add-3 (double dabble). It processes one bit per clock, so a
//   conversion takes 16 clocks after the start is accepted.
//   A fifth work digit catches values >= 10000. Those values set the
//   overflow flag, and bcd_out shows the value mod 10000.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high clear
//   start    in   conversion request, sampled only while idle
//   bin_in   in   [15:0] unsigned value, captured on the accepted start edge
//   bcd_out  out  [15:0] {thousands, hundreds, tens, ones}
//   overflow out  last converted value was >= 10000
//   busy     out  conversion in progress
//   done     out  one-cycle pulse when bcd_out/overflow update

// One BCD digit correction: add 3 when the digit is 5 or more, so the
// following left shift carries into the next decade.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bcd_converter_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin_in,
  output logic [15:0] bcd_out,
  output logic        overflow,
  output logic        busy,
  output logic        done
);
  localparam int NUM_DIG = 5;

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] work_q,  work_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] bcd_q,   bcd_d;
  logic        ovf_q,   ovf_d;
  logic        done_q,  done_d;

  // Digits after the add-3 correction. Each check uses the pre-shift value.
  logic [NUM_DIG-1:0][3:0] work_adj;

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d_i (work_q[4*g +: 4]),
      .d_o (work_adj[g])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = bin_in;
          work_d  = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // Shift {work, shift} left as one unit. The shift MSB enters work[0].
        {work_d, shift_d} = {work_adj[NUM_DIG-1:0], shift_q} << 1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          bcd_d   = work_d[15:0];
          ovf_d   = (work_d[19:16] != 4'd0);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == S_CONV);
  assign done     = done_q;
endmodule

// File: tb/tb_bcd_converter_seq.sv
module tb_bcd_converter_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] bin_in;
  logic [15:0] bcd_out;
  logic        overflow, busy, done;

  bcd_converter_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .bcd_out  (bcd_out),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal reference: {overflow, bcd} built by digit division.
  function automatic logic [16:0] bcd_model(input int v);
    int m;
    logic [3:0] d3, d2, d1, d0;
    m  = v % 10000;
    d3 = 4'(m / 1000);
    d2 = 4'((m / 100) % 10);
    d1 = 4'((m / 10) % 10);
    d0 = 4'(m % 10);
    return {v >= 10000, d3, d2, d1, d0};
  endfunction

  // Scoreboard and timing model
  logic [16:0] sb_q[$];
  logic [16:0] popped;
  int          rem   = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_bcd = '0;
  logic        m_ovf = 1'b0;
  bit          chk_en = 0;
  bit          held = 0;
  int          cyc = 0;
  int          last_done = -1;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (reset) begin
      rem   = 0;
      sb_q.delete();
      m_bcd = '0;
      m_ovf = 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        sb_q.push_back(bcd_model(int'(bin_in)));
        rem = 16;
      end
    end else begin
      rem--;
      if (rem == 0) begin
        m_done = 1'b1;
        check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          popped = sb_q.pop_front();
          m_ovf  = popped[16];
          m_bcd  = popped[15:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(rem != 0));
      check("done", 32'(done), 32'(m_done));
      check("bcd_out", 32'(bcd_out), 32'(m_bcd));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (done && held) begin
        if (last_done >= 0) check("done_period", cyc - last_done, 32'd17);
        last_done = cyc;
      end
    end
  end

  task automatic conv(input logic [15:0] v);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    repeat (18) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;   // reset must win over start
    bin_in = 16'd1234;
    repeat (3) @(negedge clk);
    start  = 1'b0;
    chk_en = 1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    conv(16'd0);
    conv(16'd1234);
    check("bcd_1234", 32'(bcd_out), 32'h1234);
    conv(16'd9999);
    check("bcd_9999", 32'(bcd_out), 32'h9999);
    conv(16'd10000);
    check("ovf_10000", 32'({overflow, bcd_out}), 32'h10000);
    conv(16'd65535);
    check("ovf_65535", 32'({overflow, bcd_out}), 32'h15535);

    // Start and bin_in changes while busy are ignored
    start  = 1'b1;
    bin_in = 16'd42;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("bcd_42", 32'(bcd_out), 32'h0042);
    conv(16'd7);
    check("bcd_7", 32'(bcd_out), 32'h0007);

    // Start held high, bin_in sweeping every cycle
    held      = 1;
    last_done = -1;
    start     = 1'b1;
    for (int i = 0; i < 720; i++) begin
      bin_in = 16'(i * 1543 + 11);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (18) @(negedge clk);
    held = 0;

    // Reset mid-conversion at iteration 8
    conv(16'd1234);
    start  = 1'b1;
    bin_in = 16'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_bcd", 32'(bcd_out), 32'h0);
    check("abort_ovf", 32'(overflow), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    conv(16'd5678);
    check("bcd_5678", 32'(bcd_out), 32'h5678);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
